eth_fcs_engine: RTL

Streaming, parametrised Ethernet CRC-32 (FCS) engine for the MII/GMII datapath. It replaces the combinational FCS finaliser with a sequential block.
- Generate mode: passes a frame through and appends the 4-byte FCS.
- Check mode: passes a frame (FCS included) through and reports FCS good/bad at end of frame.
- Sits between the MAC framer/deframer and the PHY-side nibble/byte interface, with valid/ready handshakes on both sides.

---
 rtl/eth_fcs_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/eth_fcs_engine.sv
// Streaming Ethernet CRC-32 (FCS) engine for MII (4-bit) or GMII (8-bit) beats.
// Generate mode passes the frame through and appends the FCS. Check mode passes
// the frame through, FCS included, and pulses fcs_ok/fcs_err at end of frame.
//
// Handshake: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising clock edge. Once a source raises valid,
// it holds valid and the beat payload stable until that transfer occurs.
// ready may change freely.
module eth_fcs_engine #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              fcs_ok,
  output logic              fcs_err,
  output logic              frame_abort,
  output logic [31:0]       crc_state,
  output logic [1:0]        dbg_state
);

  localparam int          FCS_BEATS = 32 / DATA_W;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE   = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(FCS_BEATS + 1);
  localparam logic [2:0]  LAST_K    = 3'(FCS_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_APPEND = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [31:0]       crc_q, crc_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [2:0]        k_q, k_n;
  logic              mode_q, mode_n;
  logic              out_valid_n, out_sof_n, out_eof_n;
  logic [DATA_W-1:0] out_data_n;
  logic              ok_n, err_n, abort_n;

  logic              out_free;
  logic              accept;
  logic [31:0]       crc_base, crc_upd;
  logic [LEN_W-1:0]  len_b;
  logic              mode_b;

  // Reflected CRC over one beat, bit 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = out_free && (state_q != S_APPEND);
  assign accept    = in_valid && in_ready;
  assign crc_state = crc_q;
  assign dbg_state = state_q;

  // Next-state, CRC/length bookkeeping and output register loading.
  always_comb begin
    state_n     = state_q;
    crc_n       = crc_q;
    len_n       = len_q;
    k_n         = k_q;
    mode_n      = mode_q;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_sof_n   = out_sof;
    out_eof_n   = out_eof;
    ok_n        = 1'b0;
    err_n       = 1'b0;
    abort_n     = 1'b0;

    // An SOF beat always restarts the CRC from init, even mid-frame.
    crc_base = crc_q;
    len_b    = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + 1'b1;
    mode_b   = mode_q;
    if (in_sof) begin
      crc_base = CRC_INIT;
      len_b    = LEN_W'(1);
      mode_b   = gen_mode;
    end
    crc_upd = crc_step(crc_base, in_data);

    // The output register empties once its beat is taken and nothing new loads.
    if (out_free) out_valid_n = 1'b0;

    case (state_q)
      S_IDLE, S_DATA: begin
        // Non-SOF beats in IDLE are accepted and dropped.
        if (accept && (in_sof || state_q == S_DATA)) begin
          if (in_sof && state_q == S_DATA) abort_n = 1'b1;
          out_valid_n = 1'b1;
          out_data_n  = in_data;
          out_sof_n   = in_sof;
          out_eof_n   = 1'b0;
          crc_n       = crc_upd;
          len_n       = len_b;
          mode_n      = mode_b;
          state_n     = S_DATA;
          if (in_eof) begin
            if (mode_b) begin
              state_n = S_APPEND;
              k_n     = 3'd0;
            end else begin
              out_eof_n = 1'b1;
              state_n   = S_IDLE;
              crc_n     = CRC_INIT;
              len_n     = '0;
              if (crc_upd == RESIDUE && len_b >= MIN_LEN) ok_n  = 1'b1;
              else                                        err_n = 1'b1;
            end
          end
        end
      end
      S_APPEND: begin
        // FCS beats go out low-order first, complemented, as the slot frees.
        if (out_free) begin
          out_valid_n = 1'b1;
          out_data_n  = ~crc_q[int'(k_q)*DATA_W +: DATA_W];
          out_sof_n   = 1'b0;
          out_eof_n   = (k_q == LAST_K);
          if (k_q == LAST_K) begin
            state_n = S_IDLE;
            crc_n   = CRC_INIT;
            len_n   = '0;
            k_n     = 3'd0;
          end else begin
            k_n = k_q + 3'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        crc_n   = CRC_INIT;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      k_q         <= 3'd0;
      mode_q      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      fcs_ok      <= 1'b0;
      fcs_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_n;
      crc_q       <= crc_n;
      len_q       <= len_n;
      k_q         <= k_n;
      mode_q      <= mode_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_sof     <= out_sof_n;
      out_eof     <= out_eof_n;
      fcs_ok      <= ok_n;
      fcs_err     <= err_n;
      frame_abort <= abort_n;
    end
  end

endmodule
